// File: rtl/ram_bist_master.sv
// ram_bist_master: write/read-back BIST initiator for a single-port RAM with 1-cycle registered read.
// Optional inverted second pass enabled by defining RAM_BIST_INV_PASS_EN.
module ram_bist_master #(
   parameter int AW    = 10,
   parameter int DW    = 8,
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [AW-1:0]    fail_addr,
   output logic             ram_cs,
   output logic             ram_wr,
   output logic             ram_rd,
   output logic [AW-1:0]    ram_addr,
   output logic [DW-1:0]    ram_wdata,
   input  logic [DW-1:0]    ram_rdata
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WRITE     = 3'd1;
   localparam logic [2:0] READ      = 3'd2;
   localparam logic [2:0] DRAIN     = 3'd3;
   localparam logic [2:0] DONE      = 3'd4;
   localparam logic [2:0] WRITE_INV = 3'd5;
   localparam logic [2:0] READ_INV  = 3'd6;
   localparam logic [2:0] DRAIN_INV = 3'd7;
`ifdef RAM_BIST_INV_PASS_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic [2:0]    state;
   logic          cmp_vld;
   logic          cmp_inv;
   logic [AW-1:0] cmp_addr;
   logic          last;
   logic          inv_ph;
   logic          start_ok;
   logic          mismatch;

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic inv);
      return DW'({a, 1'b0}) ^ {DW{inv}};
   endfunction

   // inverted-pattern states all carry state[2]; DONE never issues strobes
   assign inv_ph   = state[2];
   assign last     = &ram_addr;
   assign start_ok = start && (state == IDLE || state == DONE);
   assign mismatch = cmp_vld && (ram_rdata != pat(cmp_addr, cmp_inv));
   assign busy     = !(state == IDLE || state == DONE);
   assign done     = state == DONE;
   assign pass     = done && (err_count == '0);

   // sequencer: strobes are registered and double as phase flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ram_cs    <= 1'b0;
         ram_wr    <= 1'b0;
         ram_rd    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cmp_vld   <= 1'b0;
         cmp_inv   <= 1'b0;
         cmp_addr  <= '0;
      end else begin
         cmp_vld  <= ram_cs && ram_rd;
         cmp_inv  <= inv_ph;
         cmp_addr <= ram_addr;
         if (ram_wr) begin
            if (last) begin
               state    <= (state == WRITE) ? READ : READ_INV;
               ram_wr   <= 1'b0;
               ram_rd   <= 1'b1;
               ram_addr <= '0;
            end else begin
               ram_addr  <= ram_addr + AW'(1);
               ram_wdata <= pat(ram_addr + AW'(1), inv_ph);
            end
         end else if (ram_rd) begin
            if (last) begin
               state    <= (state == READ) ? DRAIN : DRAIN_INV;
               ram_cs   <= 1'b0;
               ram_rd   <= 1'b0;
               ram_addr <= '0;
            end else begin
               ram_addr <= ram_addr + AW'(1);
            end
         end else if (state == DRAIN || state == DRAIN_INV) begin
            if (state == DRAIN && INV_EN) begin
               state     <= WRITE_INV;
               ram_cs    <= 1'b1;
               ram_wr    <= 1'b1;
               ram_addr  <= '0;
               ram_wdata <= pat('0, 1'b1);
            end else begin
               state <= DONE;
            end
         end else if (start_ok) begin
            state     <= WRITE;
            ram_cs    <= 1'b1;
            ram_wr    <= 1'b1;
            ram_rd    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= pat('0, 1'b0);
         end
      end
   end

   // result tracking: saturating error count, first failing address
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
         fail_addr <= '0;
      end else if (start_ok) begin
         err_count <= '0;
         fail_addr <= '0;
      end else if (mismatch) begin
         if (!(&err_count)) err_count <= err_count + ERR_W'(1);
         if (err_count == '0) fail_addr <= cmp_addr;
      end
   end
endmodule

// File: tb/tb_ram_bist_master.sv
// tb_ram_bist_master: directed checks of ram_bist_master (AW=4) against a 1-cycle RAM model.
module tb_ram_bist_master;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int EW = 16;
`ifdef RAM_BIST_INV_PASS_EN
   localparam int NP = 2;
`else
   localparam int NP = 1;
`endif
   localparam int LAT = NP * 33;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          busy, done, pass;
   logic [EW-1:0] err_count;
   logic [AW-1:0] fail_addr;
   logic          ram_cs, ram_wr, ram_rd;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata = '0;
   logic [DW-1:0] mem [16];
   logic          fault5 = 1'b0;
   logic          fault9 = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;

   ram_bist_master #(.AW(AW), .DW(DW), .ERR_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_addr(fail_addr), .ram_cs(ram_cs), .ram_wr(ram_wr),
      .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM model with optional stuck-at-1 on bit0 at addresses 5 and 9
   always @(posedge clk) begin
      if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
      if (ram_cs && ram_rd)
         ram_rdata <= mem[ram_addr] | {7'b0, (fault5 && ram_addr == 4'd5) || (fault9 && ram_addr == 4'd9)};
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, pass, err_count, fail_addr, ram_cs, ram_wr, ram_rd, ram_addr, ram_wdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: busy=%b done=%b pass=%b err=%0d fa=%0d cs=%b wr=%b rd=%b addr=%0d wd=%0d, all required 0",
                  busy, done, pass, err_count, fail_addr, ram_cs, ram_wr, ram_rd, ram_addr, ram_wdata);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, done, ram_cs, ram_wr, ram_rd} !== 5'b0) begin
         n_bad++;
         $display("FAIL idle_after_reset: busy=%b done=%b cs=%b wr=%b rd=%b, required all 0", busy, done, ram_cs, ram_wr, ram_rd);
      end
   endtask

   task automatic test_clean_run();
      logic [DW-1:0] e;
      pulse_start();
      for (int p = 0; p < NP; p++) begin
         for (int k = 0; k < 16; k++) begin
            e = 8'(2 * k);
            if (p == 1) e = ~e;
            n_cmp++;
            if ({ram_cs, ram_wr, ram_rd, busy, done} !== 5'b11010 || ram_addr !== 4'(k) || ram_wdata !== e) begin
               n_bad++;
               $display("FAIL write_p%0d_k%0d: cs/wr/rd/busy/done=%b%b%b%b%b addr=%0d wd=%0d, required 11010 addr=%0d wd=%0d",
                        p, k, ram_cs, ram_wr, ram_rd, busy, done, ram_addr, ram_wdata, k, e);
            end
            @(negedge clk);
         end
         for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if ({ram_cs, ram_wr, ram_rd, busy} !== 4'b1011 || ram_addr !== 4'(k)) begin
               n_bad++;
               $display("FAIL read_p%0d_k%0d: cs/wr/rd/busy=%b%b%b%b addr=%0d, required 1011 addr=%0d",
                        p, k, ram_cs, ram_wr, ram_rd, busy, ram_addr, k);
            end
            @(negedge clk);
         end
         n_cmp++;
         if ({ram_cs, ram_wr, ram_rd, busy, done} !== 5'b00010) begin
            n_bad++;
            $display("FAIL drain_p%0d: cs/wr/rd/busy/done=%b%b%b%b%b, required 00010", p, ram_cs, ram_wr, ram_rd, busy, done);
         end
         @(negedge clk);
      end
      n_cmp++;
      if ({done, busy, pass, ram_cs} !== 4'b1010 || err_count !== 16'd0 || fail_addr !== 4'd0) begin
         n_bad++;
         $display("FAIL clean_result: done/busy/pass/cs=%b%b%b%b err=%0d fa=%0d, required 1010 err=0 fa=0",
                  done, busy, pass, ram_cs, err_count, fail_addr);
      end
   endtask

   task automatic test_faults();
      int cyc;
      fault5 = 1'b1;
      fault9 = 1'b1;
      pulse_start();
      wait_done(cyc);
      n_cmp++;
      if (cyc !== LAT) begin
         n_bad++;
         $display("FAIL fault_latency: got %0d cycles, required %0d", cyc, LAT);
      end
      n_cmp++;
      if (err_count !== 16'd2 || fail_addr !== 4'd5 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL fault_result: err=%0d fa=%0d pass=%b, required err=2 fa=5 pass=0", err_count, fail_addr, pass);
      end
   endtask

   task automatic test_restart_and_ignore();
      int cyc;
      fault5 = 1'b0;
      fault9 = 1'b0;
      pulse_start();
      n_cmp++;
      if ({done, busy, pass} !== 3'b010 || err_count !== 16'd0 || fail_addr !== 4'd0) begin
         n_bad++;
         $display("FAIL restart_clear: done/busy/pass=%b%b%b err=%0d fa=%0d, required 010 err=0 fa=0",
                  done, busy, pass, err_count, fail_addr);
      end
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      n_cmp++;
      if ({ram_wr, ram_rd} !== 2'b10 || ram_addr !== 4'd4 || ram_wdata !== 8'd8) begin
         n_bad++;
         $display("FAIL start_ignored: wr/rd=%b%b addr=%0d wd=%0d, required 10 addr=4 wd=8", ram_wr, ram_rd, ram_addr, ram_wdata);
      end
      wait_done(cyc);
      n_cmp++;
      if (cyc + 4 !== LAT || pass !== 1'b1) begin
         n_bad++;
         $display("FAIL restart_latency: got %0d cycles pass=%b, required %0d pass=1", cyc + 4, pass, LAT);
      end
   endtask

   task automatic test_reset_mid_read();
      int cyc;
      pulse_start();
      repeat (23) @(negedge clk);
      n_cmp++;
      if ({ram_cs, ram_rd} !== 2'b11 || ram_addr !== 4'd7) begin
         n_bad++;
         $display("FAIL pre_reset_read: cs/rd=%b%b addr=%0d, required 11 addr=7", ram_cs, ram_rd, ram_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ram_cs, ram_rd, ram_wr, busy, done} !== 5'b0 || ram_addr !== 4'd0 || err_count !== 16'd0) begin
         n_bad++;
         $display("FAIL async_reset: cs/rd/wr/busy/done=%b%b%b%b%b addr=%0d err=%0d, required all 0",
                  ram_cs, ram_rd, ram_wr, busy, done, ram_addr, err_count);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, ram_cs} !== 3'b0) begin
         n_bad++;
         $display("FAIL idle_after_midreset: busy/done/cs=%b%b%b, required 000", busy, done, ram_cs);
      end
      pulse_start();
      wait_done(cyc);
      n_cmp++;
      if (cyc !== LAT || pass !== 1'b1 || err_count !== 16'd0) begin
         n_bad++;
         $display("FAIL post_reset_run: cycles=%0d pass=%b err=%0d, required %0d pass=1 err=0", cyc, pass, err_count, LAT);
      end
   endtask

   initial begin
      test_reset();
      test_clean_run();
      test_faults();
      test_restart_and_ignore();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
